// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a 16-deep byte FIFO. Bytes arrive on SEND, BUSY
// throttles the upstream serializer, and frames leave back-to-back on TX:
// start bit, 8 data bits LSB first, optional parity, then 1 or 2 stop bits.
module uart_tx_fifo #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned FIFO_AW      = 4,
    parameter int unsigned PARITY_EN    = 0,
    parameter int unsigned PARITY_ODD   = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [7:0]         DATA_in,
    input  logic               SEND,
    output logic               BUSY,
    input  logic               CLR_OVF,
    output logic               TX,
    output logic               TX_ACTIVE,
    output logic               OVERFLOW,
    output logic [FIFO_AW:0]   LEVEL
);

    localparam int unsigned DEPTH = 1 << FIFO_AW;
    localparam int unsigned CW    = FIFO_AW + 1;
    localparam int unsigned BW    = $clog2(CLKS_PER_BIT);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // FIFO storage and bookkeeping
    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [CW-1:0]      count;
    logic               ovf_q;
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;
    logic [7:0]         rd_data;

    // Transmit FSM and datapath
    state_t             state;
    state_t             state_nx;
    logic [BW-1:0]      baud_cnt;
    logic [BW-1:0]      baud_nx;
    logic [2:0]         bit_idx;
    logic [2:0]         bit_nx;
    logic               stop_idx;
    logic               stop_nx;
    logic [7:0]         shift_q;
    logic [7:0]         shift_nx;
    logic               par_q;
    logic               par_nx;
    logic               tx_q;
    logic               tx_nx;
    logic               act_q;
    logic               act_nx;
    logic               bit_done;
    logic               stop_last;

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign push      = SEND && !full;
    assign rd_data   = mem[rd_ptr];
    assign bit_done  = (baud_cnt == BW'(CLKS_PER_BIT - 1));
    assign stop_last = (stop_idx == 1'(STOP_BITS - 1));

    // Two slots of headroom cover the upstream one-cycle reaction to BUSY.
    assign BUSY      = (count >= CW'(DEPTH - 2));
    assign TX        = tx_q;
    assign TX_ACTIVE = act_q;
    assign OVERFLOW  = ovf_q;
    assign LEVEL     = count;

    // FIFO write port; a full FIFO drops the byte even if a pop happens this cycle
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= DATA_in;
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + FIFO_AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + FIFO_AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (SEND && full) begin
                ovf_q <= 1'b1;
            end else if (CLR_OVF) begin
                ovf_q <= 1'b0;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic; pops happen from IDLE or at the end of the last stop bit
    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        case (state)
            S_IDLE: begin
                if (!empty) begin
                    state_nx = S_START;
                    pop      = 1'b1;
                end
            end
            S_START: begin
                if (bit_done) begin
                    state_nx = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_done && bit_idx == 3'd7) begin
                    state_nx = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (bit_done) begin
                    state_nx = S_STOP;
                end
            end
            S_STOP: begin
                if (bit_done && stop_last) begin
                    if (!empty) begin
                        state_nx = S_START;
                        pop      = 1'b1;
                    end else begin
                        state_nx = S_IDLE;
                    end
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Output and datapath next values; TX always presents the bit being sent
    always_comb begin
        tx_nx    = tx_q;
        act_nx   = act_q;
        shift_nx = shift_q;
        par_nx   = par_q;
        bit_nx   = bit_idx;
        stop_nx  = stop_idx;
        baud_nx  = bit_done ? '0 : baud_cnt + BW'(1);
        if (pop) begin
            shift_nx = rd_data;
            par_nx   = (^rd_data) ^ 1'(PARITY_ODD);
            tx_nx    = 1'b0;
            act_nx   = 1'b1;
            baud_nx  = '0;
            bit_nx   = '0;
            stop_nx  = 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    baud_nx = '0;
                    tx_nx   = 1'b1;
                    act_nx  = 1'b0;
                end
                S_START: begin
                    if (bit_done) begin
                        tx_nx = shift_q[0];
                    end
                end
                S_DATA: begin
                    if (bit_done) begin
                        if (bit_idx == 3'd7) begin
                            tx_nx = (PARITY_EN != 0) ? par_q : 1'b1;
                        end else begin
                            shift_nx = {1'b0, shift_q[7:1]};
                            tx_nx    = shift_q[1];
                            bit_nx   = bit_idx + 3'd1;
                        end
                    end
                end
                S_PARITY: begin
                    if (bit_done) begin
                        tx_nx = 1'b1;
                    end
                end
                S_STOP: begin
                    if (bit_done) begin
                        if (stop_last) begin
                            tx_nx  = 1'b1;
                            act_nx = 1'b0;
                        end else begin
                            stop_nx = stop_idx + 1'b1;
                        end
                    end
                end
                default: begin
                    tx_nx  = 1'b1;
                    act_nx = 1'b0;
                end
            endcase
        end
    end

    // Datapath registers; reset aborts any frame and idles the line high
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_q     <= 1'b1;
            act_q    <= 1'b0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            baud_cnt <= '0;
        end else begin
            tx_q     <= tx_nx;
            act_q    <= act_nx;
            shift_q  <= shift_nx;
            par_q    <= par_nx;
            bit_idx  <= bit_nx;
            stop_idx <= stop_nx;
            baud_cnt <= baud_nx;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: single frame, burst with BUSY throttling,
// overflow, parity/stop options, mid-frame reset and full-FIFO push/pop.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       rst_n;

    logic [7:0] data0;
    logic       send0;
    logic       clr0;
    logic       busy0;
    logic       tx0;
    logic       act0;
    logic       ovf0;
    logic [4:0] lvl0;

    logic [7:0] data12;
    logic       send1;
    logic       send2;
    logic       busy1, tx1, act1, ovf1;
    logic       busy2, tx2, act2, ovf2;
    logic [4:0] lvl1;
    logic [4:0] lvl2;

    int total = 0;
    int bad   = 0;
    logic [7:0] rxq[$];

    always #5 clk = ~clk;

    uart_tx_fifo #(.CLKS_PER_BIT(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .DATA_in(data0), .SEND(send0), .BUSY(busy0),
        .CLR_OVF(clr0), .TX(tx0), .TX_ACTIVE(act0), .OVERFLOW(ovf0), .LEVEL(lvl0)
    );

    uart_tx_fifo #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .DATA_in(data12), .SEND(send1), .BUSY(busy1),
        .CLR_OVF(1'b0), .TX(tx1), .TX_ACTIVE(act1), .OVERFLOW(ovf1), .LEVEL(lvl1)
    );

    uart_tx_fifo #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .DATA_in(data12), .SEND(send2), .BUSY(busy2),
        .CLR_OVF(1'b0), .TX(tx2), .TX_ACTIVE(act2), .OVERFLOW(ovf2), .LEVEL(lvl2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Decode n frames from dut0 by sampling mid-bit (4 clocks per bit)
    task automatic rx_bytes0(input int n);
        logic [7:0] b;
        int g;
        for (int f = 0; f < n; f++) begin
            g = 0;
            while (tx0 !== 1'b0 && g < 200) begin
                @(negedge clk);
                g++;
            end
            if (g >= 200) begin
                chk("rx_start_timeout", 32'(g), 32'd0);
                return;
            end
            repeat (2) @(negedge clk);
            chk("rx_start_mid", 32'(tx0), 32'd0);
            b = '0;
            for (int i = 0; i < 8; i++) begin
                repeat (4) @(negedge clk);
                b[i] = tx0;
            end
            repeat (4) @(negedge clk);
            chk("rx_stop_mid", 32'(tx0), 32'd1);
            rxq.push_back(b);
        end
    endtask

    initial begin
        logic [9:0]  fr_a5;
        logic [11:0] fr_even;
        logic [11:0] fr_odd;
        logic [7:0]  rm [4];
        int idx, guard, act_hi, act_rise, lvl_max, exp_lvl, lows;
        logic busy_prev, act_prev;
        logic [7:0] b;

        rst_n = 1'b0;
        data0 = '0; send0 = 1'b0; clr0 = 1'b0;
        data12 = '0; send1 = 1'b0; send2 = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_tx", 32'(tx0), 32'd1);
        chk("rst_act", 32'(act0), 32'd0);
        chk("rst_busy", 32'(busy0), 32'd0);
        chk("rst_ovf", 32'(ovf0), 32'd0);
        chk("rst_lvl", 32'(lvl0), 32'd0);
        chk("rst_dut1", {busy1, ovf1, tx1, act1, 3'b0, lvl1}, {1'b0, 1'b0, 1'b1, 1'b0, 3'b0, 5'd0});
        chk("rst_dut2", {busy2, ovf2, tx2, act2, 3'b0, lvl2}, {1'b0, 1'b0, 1'b1, 1'b0, 3'b0, 5'd0});
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single byte 0xA5: start, 1,0,1,0,0,1,0,1, stop
        fr_a5 = 10'h34A;
        send0 = 1'b1; data0 = 8'hA5;
        @(negedge clk);
        chk("single_lvl_push", 32'(lvl0), 32'd1);
        chk("single_tx_still_idle", 32'(tx0), 32'd1);
        send0 = 1'b0; data0 = 8'hFF;
        @(negedge clk);
        chk("single_lvl_pop", 32'(lvl0), 32'd0);
        for (int j = 0; j < 40; j++) begin
            chk($sformatf("single_tx[%0d]", j), 32'(tx0), 32'(fr_a5[j/4]));
            chk($sformatf("single_act[%0d]", j), 32'(act0), 32'd1);
            @(negedge clk);
        end
        chk("single_act_end", 32'(act0), 32'd0);
        chk("single_tx_end", 32'(tx0), 32'd1);
        chk("single_lvl_end", 32'(lvl0), 32'd0);
        repeat (4) @(negedge clk);

        // 51-byte burst with one-cycle BUSY reaction upstream
        rxq.delete();
        act_hi = 0; act_rise = 0; lvl_max = 0;
        fork
            begin
                idx = 0; guard = 0; busy_prev = 1'b0;
                while (idx < 51 && guard < 5000) begin
                    send0 = !busy_prev;
                    data0 = 8'(idx);
                    busy_prev = busy0;
                    @(negedge clk);
                    if (send0) idx++;
                    guard++;
                end
                send0 = 1'b0;
                chk("burst_all_sent", 32'(idx), 32'd51);
            end
            begin
                act_prev = act0;
                for (int c = 0; c < 2200; c++) begin
                    @(negedge clk);
                    if (act0) act_hi++;
                    if (act0 && !act_prev) act_rise++;
                    if (int'(lvl0) > lvl_max) lvl_max = int'(lvl0);
                    act_prev = act0;
                end
            end
            rx_bytes0(51);
        join
        chk("burst_rx_count", 32'(rxq.size()), 32'd51);
        for (int i = 0; i < rxq.size(); i++) begin
            chk($sformatf("burst_byte[%0d]", i), 32'(rxq[i]), 32'(i));
        end
        chk("burst_ovf", 32'(ovf0), 32'd0);
        chk("burst_active_cycles", 32'(act_hi), 32'd2040);
        chk("burst_active_rises", 32'(act_rise), 32'd1);
        chk("burst_lvl_le16", 32'(lvl_max <= 16), 32'd1);
        repeat (10) @(negedge clk);

        // Overflow: SEND held 20 cycles, then push at the STOP-end pop with FIFO full
        rxq.delete();
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    send0 = 1'b1;
                    data0 = 8'(8'h40 + i);
                    @(negedge clk);
                    exp_lvl = (i == 0) ? 1 : ((i > 16) ? 16 : i);
                    chk($sformatf("ovf_lvl[%0d]", i + 1), 32'(lvl0), 32'(exp_lvl));
                    chk($sformatf("ovf_busy[%0d]", i + 1), 32'(busy0), 32'(exp_lvl >= 14));
                    chk($sformatf("ovf_flag[%0d]", i + 1), 32'(ovf0), 32'(i >= 17));
                end
                send0 = 1'b0;
                @(negedge clk);
                chk("ovf_sticky", 32'(ovf0), 32'd1);
                clr0 = 1'b1;
                @(negedge clk);
                chk("ovf_cleared", 32'(ovf0), 32'd0);
                clr0 = 1'b0;
                repeat (19) @(negedge clk);
                chk("full_lvl_before", 32'(lvl0), 32'd16);
                chk("full_act_before", 32'(act0), 32'd1);
                send0 = 1'b1; data0 = 8'hEE;
                @(negedge clk);
                send0 = 1'b0;
                chk("full_pushpop_lvl", 32'(lvl0), 32'd15);
                chk("full_pushpop_ovf", 32'(ovf0), 32'd1);
                chk("full_next_start", 32'(tx0), 32'd0);
            end
            rx_bytes0(17);
        join
        chk("ovf_rx_count", 32'(rxq.size()), 32'd17);
        for (int i = 0; i < rxq.size(); i++) begin
            chk($sformatf("ovf_byte[%0d]", i), 32'(rxq[i]), 32'(8'h40 + i));
        end
        repeat (10) @(negedge clk);
        chk("ovf_idle_lvl", 32'(lvl0), 32'd0);

        // Parity even / odd with two stop bits on 0x07
        fr_even = 12'hE0E;
        fr_odd  = 12'hC0E;
        send1 = 1'b1; send2 = 1'b1; data12 = 8'h07;
        @(negedge clk);
        send1 = 1'b0; send2 = 1'b0;
        @(negedge clk);
        for (int j = 0; j < 48; j++) begin
            if (j % 4 == 2) begin
                chk($sformatf("par_even_tx[%0d]", j / 4), 32'(tx1), 32'(fr_even[j/4]));
                chk($sformatf("par_odd_tx[%0d]", j / 4), 32'(tx2), 32'(fr_odd[j/4]));
            end
            chk($sformatf("par_act[%0d]", j), {act1, act2}, 32'd3);
            @(negedge clk);
        end
        chk("par_act_end", {act1, act2}, 32'd0);

        // Reset during data bit 3 of 0x5A with 3 bytes queued
        clr0 = 1'b1;
        @(negedge clk);
        clr0 = 1'b0;
        chk("rm_ovf_clr", 32'(ovf0), 32'd0);
        rm[0] = 8'h5A; rm[1] = 8'h11; rm[2] = 8'h22; rm[3] = 8'h33;
        for (int i = 0; i < 4; i++) begin
            send0 = 1'b1; data0 = rm[i];
            @(negedge clk);
        end
        send0 = 1'b0;
        chk("rm_lvl_queued", 32'(lvl0), 32'd3);
        repeat (11) @(negedge clk);
        chk("rm_bit2", 32'(tx0), 32'd0);
        repeat (4) @(negedge clk);
        chk("rm_bit3", 32'(tx0), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rm_tx", 32'(tx0), 32'd1);
        chk("rm_act", 32'(act0), 32'd0);
        chk("rm_lvl", 32'(lvl0), 32'd0);
        chk("rm_busy", 32'(busy0), 32'd0);
        lows = 0;
        for (int c = 0; c < 150; c++) begin
            @(negedge clk);
            if (!tx0 || act0) lows++;
        end
        chk("rm_quiet", 32'(lows), 32'd0);
        rxq.delete();
        send0 = 1'b1; data0 = 8'h3C;
        @(negedge clk);
        send0 = 1'b0;
        rx_bytes0(1);
        b = (rxq.size() > 0) ? rxq[0] : 8'h00;
        chk("rm_resume_byte", 32'(b), 32'h3C);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- UART transmitter with a byte FIFO; sits directly downstream of the DMA-SPI byte serializer.
- Accepts bytes on a SEND strobe and feeds back BUSY to throttle the serializer.
- Drives a 8-bit, LSB-first serial line, with optional parity and 1 or 2 stop bits.
- The FIFO absorbs the serializer's one-cycle reaction latency to BUSY, so 51-byte bursts go out back-to-back with no gaps.

Parameters:
- CLKS_PER_BIT, 868: clk cycles per bit (100 MHz / 115200); legal range ≥2.
- FIFO_AW, 4: FIFO address width; depth DEPTH = 2**FIFO_AW = 16.
- PARITY_EN, 0: 1 = insert a parity bit after data bit 7.
- PARITY_ODD, 0: 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0.
- STOP_BITS, 1: 1 or 2.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous, active-low reset.
- DATA_in  in  8  byte to transmit.
- SEND  in  1  write strobe; DATA_in captured on every clk edge where SEND=1.
- BUSY  out  1  throttle to upstream: 1 when FIFO count ≥ DEPTH-2.
- CLR_OVF  in  1  clears OVERFLOW.
- TX  out  1  serial line, idle high.
- TX_ACTIVE  out  1  1 from start bit through last stop bit.
- OVERFLOW  out  1  sticky: a write was dropped.
- LEVEL  out  FIFO_AW+1  current FIFO occupancy, 0..DEPTH.

Behaviour:
- Reset values (next edge with rst_n=0): TX=1, TX_ACTIVE=0, BUSY=0, OVERFLOW=0, LEVEL=0.
  - Reset also clears the FIFO and puts the FSM in IDLE.
  - A frame in progress is aborted: TX goes high at that edge and the frame is not resumed.
- FIFO write:
  - Accepted iff SEND=1 and count<DEPTH, sampled before the edge.
  - SEND=1 with count=DEPTH: byte dropped, OVERFLOW←1. This holds even if a pop happens in the same cycle.
- FIFO read (pop): only by the FSM, as described below.
- Simultaneous push and pop: count unchanged.
- Pointers wrap modulo DEPTH.
- BUSY is combinational from the registered count.
  - The DEPTH-2 threshold leaves 2 slots of margin for the upstream one-cycle latency between seeing BUSY=0 and driving SEND.
- OVERFLOW clears on CLR_OVF=1.
  - If an overflow occurs in the same cycle as CLR_OVF, set wins.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- Baud counter: counts 0..CLKS_PER_BIT-1; each bit lasts exactly CLKS_PER_BIT cycles.
- IDLE:
  - If FIFO is non-empty: pop, load shift register, TX←0, TX_ACTIVE←1, go to START.
  - A byte written at edge k into an empty FIFO with the FSM idle drives TX low at edge k+1.
- START → DATA after one bit.
- DATA: 8 bits, LSB first; bit index 0..7; TX = shift[0] each bit.
- DATA exit after bit 7: to PARITY if PARITY_EN, else to STOP.
- PARITY: bit value = XOR of the 8 data bits, XOR PARITY_ODD.
- STOP: TX=1 for STOP_BITS bits.
  - At the final stop-bit edge with FIFO non-empty: pop and go directly to START (TX←0), with no idle cycle.
  - Otherwise go to IDLE with TX_ACTIVE←0.
- Frame length: (10 + PARITY_EN + STOP_BITS-1) × CLKS_PER_BIT cycles.
- Byte order on TX equals SEND order.
- DATA_in is ignored when SEND=0.

Test Plan:
- Single byte, CLKS_PER_BIT=4, defaults: SEND one cycle with 0xA5.
  - TX low at next edge.
  - TX bits 0,1,0,1,0,0,1,0,1,1, each 4 cycles (start, data LSB-first, stop).
  - TX_ACTIVE high 40 cycles; LEVEL returns to 0.
- 51-byte burst from the serializer (bytes 0x00..0x32), CLKS_PER_BIT=4.
  - All 51 bytes decoded in order; OVERFLOW=0.
  - Frames contiguous: 2040 cycles from first start bit to last stop-bit end.
  - LEVEL never exceeds 16.
- Overflow, CLKS_PER_BIT=4, FIFO empty/idle: SEND held high for 20 cycles, ignoring BUSY.
  - 17 bytes transmitted (1 in shift register + 16 in FIFO); 3 dropped.
  - OVERFLOW=1 after the 18th write.
  - BUSY=1 from count 14.
  - CLR_OVF pulse → OVERFLOW=0.
- Parity/stop options, PARITY_EN=1, PARITY_ODD=0, STOP_BITS=2: byte 0x07.
  - Parity bit = 1; two stop bits; frame = 12×CLKS_PER_BIT cycles.
  - Repeat with PARITY_ODD=1 → parity bit = 0.
- Reset mid-frame: rst_n low for 1 cycle during data bit 3 of 0x5A with 3 bytes queued.
  - TX=1, TX_ACTIVE=0, LEVEL=0, BUSY=0 after that edge.
  - No further start bit until a new SEND.
- Simultaneous push/pop at count=DEPTH: SEND=1 in the same cycle as the STOP-end pop.
  - Byte dropped, OVERFLOW=1, LEVEL goes 16→15.
